// File: rtl/cam_mem_arbiter_pkg.sv
// cam_mem_arbiter_pkg
//   Shared camera-path definitions used by the capture/CPU RAM arbiter.
//   Holds the arbiter state encoding and the default bus widths and
//   starvation limit so that every user of the arbiter agrees on them.
//
//   Contents:
//     arb_state_e    - 2-bit arbiter FSM state encoding
//     DW_DEFAULT     - capture data bus MSB index (16-bit data)
//     AW_DEFAULT     - capture word address MSB index (12-bit address)
//     MAXC_DEFAULT   - back-to-back capture grants allowed while the CPU waits
package cam_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_CAP = 2'd1,
        ST_GNT_CPU = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    localparam int DW_DEFAULT   = 15;
    localparam int AW_DEFAULT   = 11;
    localparam int MAXC_DEFAULT = 4;

endpackage

// File: rtl/cam_mem_arbiter.sv
// cam_mem_arbiter
//   Shares one synchronous single-port RAM between the capture path
//   (read/write) and the CPU (read-only). Capture normally has priority;
//   once capture has been granted MAXC times in a row while the CPU waits,
//   the CPU is served next. Every access takes IDLE -> GNT -> DONE, with the
//   requester's ack pulsing in the DONE cycle.
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset      in   asynchronous active-low reset
//     cap_req    in   capture request (level, held until cap_ack)
//     cap_we     in   capture write enable (1 = write)
//     cap_addr   in   capture word address
//     cap_wdata  in   capture write data
//     cap_ack    out  capture completion pulse
//     cap_rdata  out  capture read data, valid with cap_ack, then held
//     cpu_req    in   CPU read request (level, held until cpu_ack)
//     cpu_addr   in   CPU word address
//     cpu_ack    out  CPU completion pulse
//     cpu_rdata  out  CPU read data, valid with cpu_ack, then held
//     ram_en     out  RAM enable (registered)
//     ram_we     out  RAM write enable (registered)
//     ram_addr   out  RAM address (registered)
//     ram_wdata  out  RAM write data (registered)
//     ram_rdata  in   RAM read data, one cycle after ram_en
module cam_mem_arbiter
    import cam_mem_arbiter_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int MAXC = MAXC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_req,
    input  logic          cap_we,
    input  logic [AW:0]   cap_addr,
    input  logic [DW:0]   cap_wdata,
    output logic          cap_ack,
    output logic [DW:0]   cap_rdata,
    input  logic          cpu_req,
    input  logic [AW:0]   cpu_addr,
    output logic          cpu_ack,
    output logic [DW:0]   cpu_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW:0]   ram_addr,
    output logic [DW:0]   ram_wdata,
    input  logic [DW:0]   ram_rdata
);

    localparam int            CW     = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] MAXC_C = CW'(MAXC);

    arb_state_e    state;
    arb_state_e    next_state;
    logic          grant_cap;
    logic          grant_cpu;
    logic [CW-1:0] starve_cnt;
    logic          op_write;
    logic [DW:0]   cap_rdata_q;
    logic [DW:0]   cpu_rdata_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration and next state. Requests are only looked at in IDLE, so a
    // request still high during its own ack cycle is re-arbitrated only after
    // the FSM has returned to IDLE.
    always_comb begin
        next_state = state;
        grant_cap  = 1'b0;
        grant_cpu  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cpu_req && (!cap_req || starve_cnt == MAXC_C)) begin
                    grant_cpu  = 1'b1;
                    next_state = ST_GNT_CPU;
                end else if (cap_req) begin
                    grant_cap  = 1'b1;
                    next_state = ST_GNT_CAP;
                end
            end
            ST_GNT_CAP, ST_GNT_CPU: next_state = ST_DONE;
            ST_DONE:                next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    // RAM port, acks and read-data holding registers. The RAM strobes are
    // loaded from the winner on the granting edge and dropped on the next
    // edge, giving exactly one enabled cycle. The ack flops follow the GNT
    // states by one edge so they are high only during DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            cap_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            op_write    <= 1'b0;
            cap_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            cap_ack <= (state == ST_GNT_CAP);
            cpu_ack <= (state == ST_GNT_CPU);
            if (grant_cap) begin
                ram_en    <= 1'b1;
                ram_we    <= cap_we;
                ram_addr  <= cap_addr;
                ram_wdata <= cap_wdata;
                op_write  <= cap_we;
            end else if (grant_cpu) begin
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= cpu_addr;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
            end
            if (cap_ack && !op_write) begin
                cap_rdata_q <= ram_rdata;
            end
            if (cpu_ack) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    // Starvation counter: counts capture wins while the CPU is waiting and
    // saturates at MAXC, which is what hands the next grant to the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!cpu_req || grant_cpu) begin
            starve_cnt <= '0;
        end else if (grant_cap && starve_cnt != MAXC_C) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // RAM data arrives during DONE, so the ack cycle shows it directly and
    // the holding register covers every cycle after that.
    assign cap_rdata = (cap_ack && !op_write) ? ram_rdata : cap_rdata_q;
    assign cpu_rdata = cpu_ack ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_cam_mem_arbiter.sv
// tb_cam_mem_arbiter
//   Self-checking bench for cam_mem_arbiter with a behavioural RAM attached.
//   Directed table of single accesses, hand-written corner sequences
//   (continuous contention, reset mid-grant, request withdrawn after grant)
//   and a randomized two-requester phase checked against a shadow memory
//   and the fairness/latency rules.
module tb_cam_mem_arbiter;

    localparam int DW   = 15;
    localparam int AW   = 11;
    localparam int MAXC = 4;

    logic          clk;
    logic          reset;
    logic          cap_req;
    logic          cap_we;
    logic [AW:0]   cap_addr;
    logic [DW:0]   cap_wdata;
    logic          cap_ack;
    logic [DW:0]   cap_rdata;
    logic          cpu_req;
    logic [AW:0]   cpu_addr;
    logic          cpu_ack;
    logic [DW:0]   cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW:0]   ram_addr;
    logic [DW:0]   ram_wdata;
    logic [DW:0]   ram_rdata;

    logic          load_en;
    logic [AW:0]   load_addr;
    logic [DW:0]   load_data;
    logic [DW:0]   ram_mem [0:(1<<(AW+1))-1];

    logic [DW:0]   model_mem [int];
    logic [DW:0]   exp_cap_rd;
    logic [DW:0]   exp_cpu_rd;

    int            errors;
    int            checks;

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [AW:0] addr;
        logic [DW:0] wdata;
        logic [DW:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    cam_mem_arbiter #(.DW(DW), .AW(AW), .MAXC(MAXC)) dut (
        .clk       (clk),
        .reset     (reset),
        .cap_req   (cap_req),
        .cap_we    (cap_we),
        .cap_addr  (cap_addr),
        .cap_wdata (cap_wdata),
        .cap_ack   (cap_ack),
        .cap_rdata (cap_rdata),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural synchronous RAM: one-cycle read latency, read-before-write,
    // plus a bench-only load port used while the arbiter is held in reset.
    always @(posedge clk) begin
        if (load_en) begin
            ram_mem[load_addr] <= load_data;
        end else if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
            end
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadWord(input logic [AW:0] a, input logic [DW:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
        model_mem[int'(a)] = d;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_cpu) begin
            cpu_req  = 1'b1;
            cpu_addr = v.addr;
            cap_we   = 1'b1;
        end else begin
            cap_req   = 1'b1;
            cap_we    = v.we;
            cap_addr  = v.addr;
            cap_wdata = v.wdata;
        end
    endtask

    // One directed access: grant cycle, ack cycle, then the cycle after.
    task automatic runVector(input vec_t v);
        applyStimulus(v);
        tick();
        checkOutput("gnt_ram_en", ram_en, 1);
        checkOutput("gnt_ram_we", ram_we, (!v.is_cpu && v.we) ? 1 : 0);
        checkOutput("gnt_ram_addr", ram_addr, v.addr);
        if (!v.is_cpu && v.we) checkOutput("gnt_ram_wdata", ram_wdata, v.wdata);
        checkOutput("gnt_no_ack", {cap_ack, cpu_ack}, 0);
        tick();
        checkOutput("done_ram_en", ram_en, 0);
        checkOutput("done_cap_ack", cap_ack, v.is_cpu ? 0 : 1);
        checkOutput("done_cpu_ack", cpu_ack, v.is_cpu ? 1 : 0);
        if (v.is_cpu) begin
            checkOutput("done_cpu_rdata", cpu_rdata, v.exp_rdata);
            exp_cpu_rd = v.exp_rdata;
        end else if (!v.we) begin
            checkOutput("done_cap_rdata", cap_rdata, v.exp_rdata);
            exp_cap_rd = v.exp_rdata;
        end else begin
            model_mem[int'(v.addr)] = v.wdata;
        end
        cap_req = 1'b0;
        cpu_req = 1'b0;
        tick();
        checkOutput("after_acks_low", {cap_ack, cpu_ack}, 0);
        checkOutput("hold_cap_rdata", cap_rdata, exp_cap_rd);
        checkOutput("hold_cpu_rdata", cpu_rdata, exp_cpu_rd);
    endtask

    initial begin
        int  waited;
        bit  got;
        bit  was_cpu;
        bit  cap_done;
        bit  cpu_done;

        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        cap_req    = 1'b0;
        cap_we     = 1'b0;
        cap_addr   = '0;
        cap_wdata  = '0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        exp_cap_rd = '0;
        exp_cpu_rd = '0;

        vecs[0] = '{0, 1, 12'h005, 16'hABCD, 16'h0000};
        vecs[1] = '{1, 0, 12'h010, 16'h0000, 16'h1234};
        vecs[2] = '{0, 0, 12'h005, 16'h0000, 16'hABCD};
        vecs[3] = '{1, 0, 12'h005, 16'h0000, 16'hABCD};
        vecs[4] = '{0, 1, 12'hFFF, 16'h8001, 16'h0000};
        vecs[5] = '{1, 0, 12'hFFF, 16'h0000, 16'h8001};
        vecs[6] = '{0, 0, 12'h000, 16'h0000, 16'h0000};
        vecs[7] = '{0, 0, 12'hFFF, 16'h0000, 16'h8001};

        #1;
        checkOutput("rst_ram_en", ram_en, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_acks", {cap_ack, cpu_ack}, 0);
        checkOutput("rst_cap_rdata", cap_rdata, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);

        // Preload while the arbiter is held in reset.
        loadWord(12'h000, 16'h0000);
        loadWord(12'h010, 16'h1234);
        for (int a = 12'h100; a < 12'h120; a++) loadWord(a[AW:0], '0);
        reset = 1'b1;
        tick();
        checkOutput("post_rst_idle_en", ram_en, 0);

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) runVector(vecs[i]);

        // Both requesters held high: MAXC capture grants, then one CPU grant.
        $display("[TB] continuous contention");
        cap_req  = 1'b1;
        cap_we   = 1'b0;
        cap_addr = 12'h010;
        cpu_req  = 1'b1;
        cpu_addr = 12'h010;
        for (int i = 0; i < 3 * (MAXC + 1); i++) begin
            waited = 0;
            got    = 0;
            while (!got && waited < 10) begin
                tick();
                waited++;
                if (cap_ack || cpu_ack) got = 1;
            end
            checkOutput("contend_ack_seen", got, 1);
            checkOutput("contend_exclusive", cap_ack && cpu_ack, 0);
            was_cpu = ((i % (MAXC + 1)) == MAXC);
            checkOutput("contend_owner", cpu_ack, was_cpu);
            checkOutput("contend_spacing", waited, (i == 0) ? 2 : 3);
            if (cpu_ack) checkOutput("contend_cpu_rdata", cpu_rdata, 16'h1234);
        end
        cap_req    = 1'b0;
        cpu_req    = 1'b0;
        exp_cap_rd = 16'h1234;
        exp_cpu_rd = 16'h1234;
        tick();
        tick();

        // Reset pulled low during a capture grant aborts it without an ack.
        $display("[TB] reset during capture grant");
        cap_req   = 1'b1;
        cap_we    = 1'b1;
        cap_addr  = 12'h020;
        cap_wdata = 16'h5555;
        tick();
        checkOutput("rgnt_ram_en", ram_en, 1);
        reset = 1'b0;
        #1;
        checkOutput("rgnt_abort_en", ram_en, 0);
        checkOutput("rgnt_abort_we", ram_we, 0);
        checkOutput("rgnt_abort_addr", ram_addr, 0);
        checkOutput("rgnt_abort_rdata", {cap_rdata, cpu_rdata}, 0);
        tick();
        checkOutput("rgnt_no_ack", cap_ack, 0);
        reset = 1'b1;
        exp_cap_rd = '0;
        exp_cpu_rd = '0;
        tick();
        checkOutput("rgnt_regrant_en", ram_en, 1);
        checkOutput("rgnt_regrant_noack", cap_ack, 0);
        tick();
        checkOutput("rgnt_ack", cap_ack, 1);
        cap_req = 1'b0;
        model_mem[12'h020] = 16'h5555;
        tick();
        checkOutput("rgnt_ram_written", ram_mem[12'h020], 16'h5555);

        // Request dropped right after the grant still completes once.
        $display("[TB] request withdrawn after grant");
        cap_req   = 1'b1;
        cap_we    = 1'b1;
        cap_addr  = 12'h030;
        cap_wdata = 16'h7777;
        tick();
        checkOutput("wd_ram_we", ram_we, 1);
        cap_req = 1'b0;
        tick();
        checkOutput("wd_ack", cap_ack, 1);
        tick();
        checkOutput("wd_ack_once", cap_ack, 0);
        checkOutput("wd_ram_written", ram_mem[12'h030], 16'h7777);
        model_mem[12'h030] = 16'h7777;
        tick();
        checkOutput("wd_idle_en", ram_en, 0);

        // Randomized: two independent requesters checked against a shadow
        // memory plus the fairness and latency bounds.
        $display("[TB] random traffic");
        cap_done = 0;
        cpu_done = 0;
        fork
            begin
                int          cw;
                bit          cgot;
                bit          rwe;
                logic [AW:0] ra;
                logic [DW:0] rd;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        tick();
                        checkOutput("rnd_cap_hold", cap_rdata, exp_cap_rd);
                    end
                    rwe       = 1'($urandom_range(0, 1));
                    ra        = 12'h100 + 12'($urandom_range(0, 31));
                    rd        = 16'($urandom);
                    cap_we    = rwe;
                    cap_addr  = ra;
                    cap_wdata = rd;
                    cap_req   = 1'b1;
                    cw   = 0;
                    cgot = 0;
                    while (!cgot && cw < 60) begin
                        tick();
                        cw++;
                        if (cap_ack) cgot = 1;
                    end
                    cap_req = 1'b0;
                    checkOutput("rnd_cap_ack_seen", cgot, 1);
                    if (cgot) begin
                        if (rwe) begin
                            model_mem[int'(ra)] = rd;
                        end else begin
                            checkOutput("rnd_cap_rdata", cap_rdata, model_mem[int'(ra)]);
                            exp_cap_rd = model_mem[int'(ra)];
                        end
                    end
                end
                cap_done = 1;
            end
            begin
                int          pw;
                int          caps_seen;
                bit          pgot;
                logic [AW:0] pa;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        tick();
                        checkOutput("rnd_cpu_hold", cpu_rdata, exp_cpu_rd);
                    end
                    pa       = 12'h100 + 12'($urandom_range(0, 31));
                    cpu_addr = pa;
                    cpu_req  = 1'b1;
                    pw        = 0;
                    caps_seen = 0;
                    pgot      = 0;
                    while (!pgot && pw < 60) begin
                        tick();
                        pw++;
                        if (cap_ack) caps_seen++;
                        if (cpu_ack) pgot = 1;
                    end
                    cpu_req = 1'b0;
                    checkOutput("rnd_cpu_ack_seen", pgot, 1);
                    checkOutput("rnd_cpu_starve", caps_seen <= MAXC + 1, 1);
                    checkOutput("rnd_cpu_latency", pw <= 3 * (MAXC + 2), 1);
                    if (pgot) begin
                        checkOutput("rnd_cpu_rdata", cpu_rdata, model_mem[int'(pa)]);
                        exp_cpu_rd = model_mem[int'(pa)];
                    end
                end
                cpu_done = 1;
            end
            begin
                int cyc;
                cyc = 0;
                while (!(cap_done && cpu_done) && cyc < 20000) begin
                    tick();
                    cyc++;
                    checkOutput("rnd_ack_exclusive", cap_ack && cpu_ack, 0);
                    if (ram_we) checkOutput("rnd_we_not_cpu", ram_addr == cpu_addr && cpu_req && !cap_req, 0);
                end
                checkOutput("rnd_finished", cap_done && cpu_done, 1);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
